// File: rtl/jbi_ncio_mto_pkg.sv
// Shared constants and the lowest-set-bit helper for the NCIO mondo/PIO timeout controller.
package jbi_ncio_mto_pkg;

    localparam int unsigned MTO_NUM_TAGS = 4;
    localparam int unsigned MTO_TAG_W    = 2;
    localparam int unsigned MTO_CNT_W    = 24;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [MTO_TAG_W-1:0] mto_lowest(input logic [MTO_NUM_TAGS-1:0] vec);
        logic [MTO_TAG_W-1:0] idx;
        idx = '0;
        for (int i = MTO_NUM_TAGS - 1; i >= 0; i--) begin
            if (vec[i]) idx = MTO_TAG_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/jbi_ncio_mto_tick.sv
// Programmable interval down-counter producing the shared timeout_wrap tick.
module jbi_ncio_mto_tick
    import jbi_ncio_mto_pkg::*;
#(
    parameter int unsigned CNT_W = MTO_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] csr_tmo_val,
    output logic             timeout_wrap
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A zero count means "not loaded yet" (after reset or while disabled), so it reloads too.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q == '0 || cnt_q == CNT_W'(1)) begin
            cnt_d = csr_tmo_val;
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    assign timeout_wrap = (cnt_q == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/jbi_ncio_mto_ctl.sv
// NCIO timeout controller: tag allocation, slice set/clear, completion/timeout retirement, reports.
// Optional error log enabled by defining JBI_NCIO_MTO_ERR_LOG_EN.
module jbi_ncio_mto_ctl
    import jbi_ncio_mto_pkg::*;
#(
    parameter int unsigned NUM_TAGS = MTO_NUM_TAGS,
    parameter int unsigned TAG_W    = MTO_TAG_W,
    parameter int unsigned CNT_W    = MTO_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CNT_W-1:0]    csr_tmo_val,
    input  logic                req_vld,
    output logic                req_rdy,
    output logic [TAG_W-1:0]    req_tag,
    input  logic                cmp_vld,
    input  logic [TAG_W-1:0]    cmp_tag,
    output logic                cmp_spurious,
    output logic                timeout_wrap,
    output logic [NUM_TAGS-1:0] int_vld,
    output logic [NUM_TAGS-1:0] int_rst_l,
    input  logic [NUM_TAGS-1:0] timeout_err,
    output logic                tmo_err_vld,
    output logic [TAG_W-1:0]    tmo_err_tag
`ifdef JBI_NCIO_MTO_ERR_LOG_EN
    ,
    input  logic                err_log_clr,
    output logic                err_log_vld,
    output logic [TAG_W-1:0]    err_log_tag,
    output logic                err_log_ovf
`endif
);

    logic [NUM_TAGS-1:0] busy_q, busy_d, pend_q, pend_d;
    logic [NUM_TAGS-1:0] int_vld_q, int_rst_l_q;
    logic [NUM_TAGS-1:0] free, grant_oh, cmp_oh, tmo_set, rpt_oh;
    logic                grant, cmp_hit, rpt_fire;
    logic [TAG_W-1:0]    rpt_tag;
    logic                cmp_spurious_q, tmo_err_vld_q;
    logic [TAG_W-1:0]    tmo_err_tag_q;

    jbi_ncio_mto_tick #(
        .CNT_W (CNT_W)
    ) u_tick (
        .clk          (clk),
        .rst          (rst),
        .csr_tmo_val  (csr_tmo_val),
        .timeout_wrap (timeout_wrap)
    );

    assign free    = ~(busy_q | pend_q);
    assign req_rdy = |free;
    assign req_tag = TAG_W'(mto_lowest(MTO_NUM_TAGS'(free)));

    always_comb begin
        grant    = req_vld & req_rdy;
        grant_oh = grant ? (NUM_TAGS'(1) << req_tag) : '0;
        cmp_hit  = cmp_vld & busy_q[cmp_tag];
        cmp_oh   = cmp_hit ? (NUM_TAGS'(1) << cmp_tag) : '0;
        // Busy qualification hides the stale error while a registered clear is in flight;
        // a same-cycle completion wins over the error.
        tmo_set  = timeout_err & busy_q & ~cmp_oh;
        rpt_fire = |pend_q;
        rpt_tag  = TAG_W'(mto_lowest(MTO_NUM_TAGS'(pend_q)));
        rpt_oh   = rpt_fire ? (NUM_TAGS'(1) << rpt_tag) : '0;
        busy_d   = (busy_q | grant_oh) & ~cmp_oh & ~tmo_set;
        pend_d   = (pend_q & ~rpt_oh) | tmo_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q         <= '0;
            pend_q         <= '0;
            int_vld_q      <= '0;
            int_rst_l_q    <= '0;
            cmp_spurious_q <= 1'b0;
            tmo_err_vld_q  <= 1'b0;
            tmo_err_tag_q  <= '0;
        end else begin
            busy_q         <= busy_d;
            pend_q         <= pend_d;
            int_vld_q      <= grant_oh;
            int_rst_l_q    <= ~(cmp_oh | tmo_set);
            cmp_spurious_q <= cmp_vld & ~busy_q[cmp_tag];
            tmo_err_vld_q  <= rpt_fire;
            if (rpt_fire) tmo_err_tag_q <= rpt_tag;
        end
    end

    assign int_vld      = int_vld_q;
    assign int_rst_l    = int_rst_l_q;
    assign cmp_spurious = cmp_spurious_q;
    assign tmo_err_vld  = tmo_err_vld_q;
    assign tmo_err_tag  = tmo_err_tag_q;

`ifdef JBI_NCIO_MTO_ERR_LOG_EN
    logic             err_log_vld_q, err_log_ovf_q;
    logic [TAG_W-1:0] err_log_tag_q;

    // A report coinciding with clear is kept as a fresh first error.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_log_vld_q <= 1'b0;
            err_log_tag_q <= '0;
            err_log_ovf_q <= 1'b0;
        end else if (err_log_clr) begin
            err_log_vld_q <= rpt_fire;
            err_log_tag_q <= rpt_fire ? rpt_tag : '0;
            err_log_ovf_q <= 1'b0;
        end else if (rpt_fire) begin
            if (err_log_vld_q) begin
                err_log_ovf_q <= 1'b1;
            end else begin
                err_log_vld_q <= 1'b1;
                err_log_tag_q <= rpt_tag;
            end
        end
    end

    assign err_log_vld = err_log_vld_q;
    assign err_log_tag = err_log_tag_q;
    assign err_log_ovf = err_log_ovf_q;
`endif

endmodule

// File: tb/tb_jbi_ncio_mto_ctl.sv
// Self-checking bench for jbi_ncio_mto_ctl: tag-status model plus directed literal checks.
module tb_jbi_ncio_mto_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] csr_tmo_val;
    logic        req_vld;
    logic        req_rdy;
    logic [1:0]  req_tag;
    logic        cmp_vld;
    logic [1:0]  cmp_tag;
    logic        cmp_spurious;
    logic        timeout_wrap;
    logic [3:0]  int_vld;
    logic [3:0]  int_rst_l;
    logic [3:0]  timeout_err;
    logic        tmo_err_vld;
    logic [1:0]  tmo_err_tag;
`ifdef JBI_NCIO_MTO_ERR_LOG_EN
    logic        err_log_clr;
    logic        err_log_vld;
    logic [1:0]  err_log_tag;
    logic        err_log_ovf;
`endif

    always #5 clk = ~clk;

    jbi_ncio_mto_ctl dut (
        .clk          (clk),
        .rst          (rst),
        .csr_tmo_val  (csr_tmo_val),
        .req_vld      (req_vld),
        .req_rdy      (req_rdy),
        .req_tag      (req_tag),
        .cmp_vld      (cmp_vld),
        .cmp_tag      (cmp_tag),
        .cmp_spurious (cmp_spurious),
        .timeout_wrap (timeout_wrap),
        .int_vld      (int_vld),
        .int_rst_l    (int_rst_l),
        .timeout_err  (timeout_err),
        .tmo_err_vld  (tmo_err_vld),
        .tmo_err_tag  (tmo_err_tag)
`ifdef JBI_NCIO_MTO_ERR_LOG_EN
        ,
        .err_log_clr  (err_log_clr),
        .err_log_vld  (err_log_vld),
        .err_log_tag  (err_log_tag),
        .err_log_ovf  (err_log_ovf)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each tag is 0 free, 1 busy, 2 awaiting report. Tick modelled as absolute cycle numbers.
    int          st[4];
    int          cyc       = 0;
    int          load_at   = 0;
    int          next_tick = -1;
    bit          started   = 0;
    logic [3:0]  e_int_vld, e_int_rst_l;
    logic        e_spur, e_tvld;
    logic [1:0]  e_ttag;
`ifdef JBI_NCIO_MTO_ERR_LOG_EN
    logic        e_lvld, e_lovf;
    logic [1:0]  e_ltag;
`endif

    always @(posedge clk) begin
        int s0[4];
        int g, r;
        logic [3:0] done, tmo;
        s0 = st;
        if (rst) begin
            for (int i = 0; i < 4; i++) st[i] = 0;
            e_int_vld   = 4'h0;
            e_int_rst_l = 4'h0;
            e_spur      = 1'b0;
            e_tvld      = 1'b0;
            e_ttag      = 2'd0;
            load_at     = cyc + 1;
            next_tick   = -1;
`ifdef JBI_NCIO_MTO_ERR_LOG_EN
            e_lvld = 1'b0; e_lovf = 1'b0; e_ltag = 2'd0;
`endif
        end else begin
            g = -1;
            if (req_vld) for (int i = 0; i < 4; i++) if (s0[i] == 0 && g < 0) g = i;
            done   = 4'h0;
            e_spur = 1'b0;
            if (cmp_vld) begin
                if (s0[int'(cmp_tag)] == 1) done[cmp_tag] = 1'b1;
                else e_spur = 1'b1;
            end
            tmo = 4'h0;
            for (int i = 0; i < 4; i++)
                if (s0[i] == 1 && timeout_err[i] && !done[i]) tmo[i] = 1'b1;
            r = -1;
            for (int i = 0; i < 4; i++) if (s0[i] == 2 && r < 0) r = i;
            e_int_vld = 4'h0;
            if (g >= 0) begin
                st[g] = 1;
                e_int_vld[g] = 1'b1;
            end
            for (int i = 0; i < 4; i++) begin
                if (done[i]) st[i] = 0;
                if (tmo[i]) st[i] = 2;
            end
            e_tvld = (r >= 0);
            if (r >= 0) begin
                st[r]  = 0;
                e_ttag = 2'(r);
            end
            e_int_rst_l = ~(done | tmo);
`ifdef JBI_NCIO_MTO_ERR_LOG_EN
            if (err_log_clr) begin
                e_lvld = (r >= 0);
                e_ltag = (r >= 0) ? 2'(r) : 2'd0;
                e_lovf = 1'b0;
            end else if (r >= 0) begin
                if (e_lvld) e_lovf = 1'b1;
                else begin
                    e_lvld = 1'b1;
                    e_ltag = 2'(r);
                end
            end
`endif
            if (cyc == load_at) begin
                if (csr_tmo_val == 24'd0) load_at = cyc + 1;
                else begin
                    next_tick = cyc + int'(csr_tmo_val);
                    load_at   = next_tick;
                end
            end
        end
        cyc++;
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            int fr;
            fr = -1;
            for (int i = 0; i < 4; i++) if (st[i] == 0 && fr < 0) fr = i;
            check("req_rdy", 32'(req_rdy), 32'(fr >= 0));
            if (fr >= 0) check("req_tag", 32'(req_tag), 32'(fr));
            check("timeout_wrap", 32'(timeout_wrap), 32'(cyc == next_tick));
            check("int_vld", 32'(int_vld), 32'(e_int_vld));
            check("int_rst_l", 32'(int_rst_l), 32'(e_int_rst_l));
            check("cmp_spurious", 32'(cmp_spurious), 32'(e_spur));
            check("tmo_err_vld", 32'(tmo_err_vld), 32'(e_tvld));
            if (e_tvld) check("tmo_err_tag", 32'(tmo_err_tag), 32'(e_ttag));
`ifdef JBI_NCIO_MTO_ERR_LOG_EN
            check("err_log_vld", 32'(err_log_vld), 32'(e_lvld));
            check("err_log_tag", 32'(err_log_tag), 32'(e_ltag));
            check("err_log_ovf", 32'(err_log_ovf), 32'(e_lovf));
`endif
        end
    end

    int wraps[$];
    int exp_wraps[6] = '{5, 10, 15, 18, 21, 24};

    initial begin
        rst = 1'b1; csr_tmo_val = 24'd5; req_vld = 1'b0; cmp_vld = 1'b0;
        cmp_tag = 2'd0; timeout_err = 4'h0;
`ifdef JBI_NCIO_MTO_ERR_LOG_EN
        err_log_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("lit_rst_int_rst_l", 32'(int_rst_l), 32'h0);
        check("lit_rst_int_vld", 32'(int_vld), 32'h0);
        rst = 1'b0;

        // Tick: period 5, csr=3 written mid-count, then 0 stops ticks.
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            if (timeout_wrap) wraps.push_back(k);
            if (k == 12) csr_tmo_val = 24'd3;
            if (k == 22) csr_tmo_val = 24'd0;
        end
        check("lit_wrap_count", 32'(wraps.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            if (i < wraps.size()) check("lit_wrap_cycle", 32'(wraps[i]), 32'(exp_wraps[i]));
        check("lit_rdy_after_reset", 32'(req_rdy), 32'd1);
        check("lit_int_rst_l_idle", 32'(int_rst_l), 32'hF);

        // Four back-to-back grants, then reuse of a completed tag.
        req_vld = 1'b1;
        check("lit_grant0", 32'(req_tag), 32'd0);
        for (int t = 1; t < 4; t++) begin
            @(negedge clk);
            check("lit_grant_seq", 32'(req_tag), 32'(t));
        end
        @(negedge clk);
        check("lit_full_rdy", 32'(req_rdy), 32'd0);
        req_vld = 1'b0; cmp_vld = 1'b1; cmp_tag = 2'd1;
        @(negedge clk);
        cmp_vld = 1'b0;
        check("lit_cmp_clear", 32'(int_rst_l), 32'hD);
        check("lit_regrant_tag", 32'(req_tag), 32'd1);
        req_vld = 1'b1;
        @(negedge clk);
        req_vld = 1'b0;
        check("lit_regrant_set", 32'(int_vld), 32'h2);
        for (int t = 0; t < 4; t++) begin
            cmp_vld = 1'b1; cmp_tag = 2'(t);
            @(negedge clk);
        end
        cmp_vld = 1'b0;

        // Timeout on tag 0; error held an extra cycle to exercise the busy mask.
        req_vld = 1'b1;
        @(negedge clk);
        req_vld = 1'b0;
        repeat (2) @(negedge clk);
        timeout_err = 4'h1;
        @(negedge clk);
        check("lit_tmo_clear", 32'(int_rst_l), 32'hE);
        check("lit_tmo_tag_held", 32'(req_tag), 32'd1);
        check("lit_tmo_not_yet", 32'(tmo_err_vld), 32'd0);
        @(negedge clk);
        timeout_err = 4'h0;
        check("lit_tmo_rpt", 32'(tmo_err_vld), 32'd1);
        check("lit_tmo_rpt_tag", 32'(tmo_err_tag), 32'd0);
        check("lit_tmo_masked", 32'(int_rst_l), 32'hF);
        check("lit_tmo_tag_free", 32'(req_tag), 32'd0);

        // Completion beats a same-cycle timeout, alongside a grant on another tag.
        req_vld = 1'b1;
        repeat (3) @(negedge clk);
        cmp_vld = 1'b1; cmp_tag = 2'd2; timeout_err = 4'h4;
        @(negedge clk);
        req_vld = 1'b0; cmp_vld = 1'b0; timeout_err = 4'h0;
        check("lit_race_clear", 32'(int_rst_l), 32'hB);
        check("lit_race_grant", 32'(int_vld), 32'h8);
        @(negedge clk);
        check("lit_race_no_rpt", 32'(tmo_err_vld), 32'd0);
        cmp_vld = 1'b1; cmp_tag = 2'd2;
        @(negedge clk);
        cmp_vld = 1'b0;
        check("lit_spurious", 32'(cmp_spurious), 32'd1);
        @(negedge clk);
        check("lit_spurious_pulse", 32'(cmp_spurious), 32'd0);

        // Multiple timeouts drain lowest first; reset during the drain.
        req_vld = 1'b1;
        @(negedge clk);
        req_vld = 1'b0;
        check("lit_all_busy", 32'(req_rdy), 32'd0);
        timeout_err = 4'hD;
        @(negedge clk);
        timeout_err = 4'h0;
        @(negedge clk);
        check("lit_drain0", 32'(tmo_err_tag), 32'd0);
        @(negedge clk);
        check("lit_drain1", 32'(tmo_err_tag), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        check("lit_mid_rst_rpt", 32'(tmo_err_vld), 32'd0);
        check("lit_mid_rst_clear", 32'(int_rst_l), 32'h0);
        check("lit_mid_rst_rdy", 32'(req_rdy), 32'd1);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("lit_no_late_rpt", 32'(tmo_err_vld), 32'd0);

`ifdef JBI_NCIO_MTO_ERR_LOG_EN
        req_vld = 1'b1;
        repeat (4) @(negedge clk);
        req_vld = 1'b0;
        timeout_err = 4'h2;
        @(negedge clk);
        timeout_err = 4'h0;
        @(negedge clk);
        timeout_err = 4'h8;
        @(negedge clk);
        timeout_err = 4'h0;
        @(negedge clk);
        check("lit_log_tag", 32'(err_log_tag), 32'd1);
        check("lit_log_ovf", 32'(err_log_ovf), 32'd1);
        err_log_clr = 1'b1;
        @(negedge clk);
        err_log_clr = 1'b0;
        check("lit_log_clr_vld", 32'(err_log_vld), 32'd0);
        check("lit_log_clr_ovf", 32'(err_log_ovf), 32'd0);
        timeout_err = 4'h1;
        @(negedge clk);
        timeout_err = 4'h0;
        @(negedge clk);
        check("lit_log_fresh_vld", 32'(err_log_vld), 32'd1);
        check("lit_log_fresh_tag", 32'(err_log_tag), 32'd0);
        check("lit_log_fresh_ovf", 32'(err_log_ovf), 32'd0);
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
